// File: rtl/branch_pkg.sv
// Shared variant codes and FSM encoding for the branch resolve unit and decode.
package branch_pkg;

    localparam logic [3:0] VAR_J   = 4'b1000;
    localparam logic [3:0] VAR_JR  = 4'b1001;
    localparam logic [3:0] VAR_BEQ = 4'b1010;
    localparam logic [3:0] VAR_JAL = 4'b1011;
    localparam logic [3:0] VAR_BNE = 4'b1100;
    localparam logic [3:0] VAR_BLT = 4'b1101;
    localparam logic [3:0] VAR_RET = 4'b1110;

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } brs_state_e;

endpackage

// File: rtl/branch_resolve_unit_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty is ignored.
module ras_stack #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    top_idx;

    // ptr points at the next free slot, so the top lives one below it.
    assign top_idx = ptr_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign count   = count_q;

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && (count_q != '0)) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset; only ptr/count decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves jump/branch/call/return one cycle after issue, keeps a RAS for
// call/return pairs and squashes SHADOW_SLOTS cycles after each taken transfer.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int RAS_DEPTH    = 4,
    parameter int SHADOW_SLOTS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       stall,
    input  logic [WIDTH-1:0]           pc_plus_two,
    input  logic [WIDTH-1:0]           reg_rs,
    input  logic [WIDTH-1:0]           reg_rt,
    input  logic [WIDTH-1:0]           imm,
    input  logic [3:0]                 branch_variant,
    output logic                       out_valid,
    output logic                       pc_src,
    output logic [WIDTH-1:0]           jump_address,
    output logic                       flush,
    output logic                       ra_write,
    output logic [WIDTH-1:0]           ra_write_value,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_underflow
);

    localparam int SW = $clog2(SHADOW_SLOTS + 1);

    brs_state_e        state_q, state_d;
    logic [SW-1:0]     shadow_cnt_q, shadow_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              pc_src_q, pc_src_d;
    logic [WIDTH-1:0]  jump_address_q, jump_address_d;
    logic              flush_q, flush_d;
    logic              ra_write_q, ra_write_d;
    logic [WIDTH-1:0]  ra_write_value_q, ra_write_value_d;
    logic              ras_underflow_q, ras_underflow_d;

    logic                       accept;
    logic                       taken;
    logic                       is_call;
    logic                       pop_req;
    logic                       underflow;
    logic [WIDTH-1:0]           target;
    logic [WIDTH-1:0]           branch_target;
    logic signed [WIDTH-1:0]    rs_s;
    logic signed [WIDTH-1:0]    rt_s;
    logic [WIDTH-1:0]           ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;

    assign accept        = in_valid & ~stall & (state_q == RUN);
    assign branch_target = pc_plus_two + (imm << 1);
    assign rs_s          = reg_rs;
    assign rt_s          = reg_rt;

    always_comb begin
        taken     = 1'b0;
        is_call   = 1'b0;
        pop_req   = 1'b0;
        underflow = 1'b0;
        target    = branch_target;
        case (branch_variant)
            VAR_J:   begin taken = 1'b1; target = imm; end
            VAR_JR:  begin taken = 1'b1; target = reg_rs; end
            VAR_BEQ: taken = (reg_rs == reg_rt);
            VAR_BNE: taken = (reg_rs != reg_rt);
            VAR_BLT: taken = (rs_s < rt_s);
            VAR_JAL: begin taken = 1'b1; target = imm; is_call = 1'b1; end
            VAR_RET: begin
                taken = 1'b1;
                if (ras_cnt != '0) begin
                    pop_req = 1'b1;
                    target  = ras_top;
                end else begin
                    underflow = 1'b1;
                    target    = reg_rs;
                end
            end
            // Unknown codes resolve as a harmless fall-through.
            default: target = pc_plus_two;
        endcase
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (accept & is_call),
        .pop       (accept & pop_req),
        .push_data (pc_plus_two),
        .top       (ras_top),
        .count     (ras_cnt)
    );

    always_comb begin
        out_valid_d      = accept;
        flush_d          = accept & taken;
        ra_write_d       = accept & is_call;
        ras_underflow_d  = accept & underflow;
        pc_src_d         = accept ? taken : pc_src_q;
        jump_address_d   = accept ? target : jump_address_q;
        ra_write_value_d = (accept & is_call) ? pc_plus_two : ra_write_value_q;

        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        if (state_q == RUN) begin
            if (accept && taken) begin
                state_d      = SHADOW;
                shadow_cnt_d = SW'(SHADOW_SLOTS);
            end
        end else if (!stall) begin
            if (shadow_cnt_q == SW'(1)) begin
                state_d      = RUN;
                shadow_cnt_d = '0;
            end else begin
                shadow_cnt_d = shadow_cnt_q - SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            shadow_cnt_q     <= '0;
            out_valid_q      <= 1'b0;
            pc_src_q         <= 1'b0;
            jump_address_q   <= '0;
            flush_q          <= 1'b0;
            ra_write_q       <= 1'b0;
            ra_write_value_q <= '0;
            ras_underflow_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            shadow_cnt_q     <= shadow_cnt_d;
            out_valid_q      <= out_valid_d;
            pc_src_q         <= pc_src_d;
            jump_address_q   <= jump_address_d;
            flush_q          <= flush_d;
            ra_write_q       <= ra_write_d;
            ra_write_value_q <= ra_write_value_d;
            ras_underflow_q  <= ras_underflow_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign pc_src         = pc_src_q;
    assign jump_address   = jump_address_q;
    assign flush          = flush_q;
    assign ra_write       = ra_write_q;
    assign ra_write_value = ra_write_value_q;
    assign ras_count      = ras_cnt;
    assign ras_underflow  = ras_underflow_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the combinational jump unit.
- Resolves jump, branch, call and return variants one cycle after issue, with registered outputs.
- Keeps a return-address stack (RAS) for call/return pairs.
- Squashes a configurable number of shadow slots after every taken transfer.
- Sits between decode/register-read and the PC/fetch stage; drives PC redirect, flush and the ra write port.

Parameters:
- WIDTH, 16, data/address width of PC, registers and immediates.
- RAS_DEPTH, 4, number of RAS entries (power of two, >=2).
- SHADOW_SLOTS, 1, cycles squashed after a taken transfer (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents a transfer-class instruction this cycle.
- stall  in  1  pipeline stall; when high nothing is accepted and all state holds.
- pc_plus_two  in  WIDTH  PC of the issuing instruction + 2.
- reg_rs  in  WIDTH  rs value.
- reg_rt  in  WIDTH  rt value.
- imm  in  WIDTH  absolute target (J/JAL) or signed halfword offset (branches).
- branch_variant  in  4  variant code, listed in Behaviour.
- out_valid  out  1  registered result valid.
- pc_src  out  1  1 = fetch redirects to jump_address.
- jump_address  out  WIDTH  resolved target.
- flush  out  1  one-cycle pulse; fetch/decode discard younger instructions.
- ra_write  out  1  write ra_write_value to ra.
- ra_write_value  out  WIDTH  link value (pc_plus_two of the JAL).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_underflow  out  1  one-cycle pulse: RET with empty RAS.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: out_valid=0, pc_src=0, jump_address=0, flush=0, ra_write=0, ra_write_value=0, ras_count=0, ras_underflow=0. RAS pointer=0. FSM=RUN.
- Reset mid-shadow: abandons the shadow immediately.
- Accept condition: in_valid & ~stall & state==RUN.
- Latency: outputs are registered one cycle after accept. out_valid, flush, ra_write and ras_underflow are one-cycle pulses. jump_address and pc_src hold until the next accept.
- Variant codes:
  - 1000 J: taken, target=imm.
  - 1001 JR: taken, target=reg_rs.
  - 1010 BEQ: taken iff reg_rs==reg_rt.
  - 1100 BNE: taken iff reg_rs!=reg_rt.
  - 1101 BLT: taken iff signed reg_rs < signed reg_rt.
  - 1011 JAL: taken, target=imm; ra_write=1; push pc_plus_two.
  - 1110 RET: taken; target = popped RAS top, or reg_rs if the RAS is empty, with ras_underflow=1.
  - Any other code: out_valid=1, pc_src=0, no side effects. Never X.
- Branch target: pc_plus_two + (imm<<1), truncated to WIDTH bits (wraps modulo 2^WIDTH).
- Not-taken branch: pc_src=0, flush=0, jump_address = computed target anyway.
- RAS:
  - Circular buffer.
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - Pop when empty leaves ras_count at 0.
  - Push/pop occur only on accept.
- FSM:
  - RUN: on accept of a taken transfer, go to SHADOW with shadow_cnt=SHADOW_SLOTS; flush pulses with the result.
  - SHADOW: in_valid is ignored (squashed), with no RAS or output change. shadow_cnt decrements on each cycle with ~stall; at 1 -> RUN.
  - Stall in SHADOW freezes the counter.
- Stall in RUN: nothing is accepted and registered outputs keep their values, but the pulse outputs (out_valid, flush, ra_write, ras_underflow) still clear after their single cycle.

Decomposition:
- Shared package branch_pkg: 4-bit variant localparams (VAR_J, VAR_JR, VAR_BEQ, VAR_JAL, VAR_BNE, VAR_BLT, VAR_RET) and the FSM state encoding, reused by decode.
- One sub-module, ras_stack (parameters WIDTH, RAS_DEPTH; push/pop/top/count). The rest is inline.

Test Plan:
- Reset, then BEQ with pc_plus_two=0x0010, imm=0x0004, rs=rt=5 -> next cycle pc_src=1, jump_address=0x0018, flush=1. A second in_valid the following cycle is ignored.
- BNE with rs=rt=7 -> pc_src=0, flush=0, out_valid=1, FSM stays RUN. A back-to-back BLT with rs=0xFFFF, rt=0x0001 is taken (signed compare).
- JAL from pc_plus_two=0x0100 five times, RAS_DEPTH=4 -> ras_count=4. Four RETs target 0x0100 (all entries equal). A fifth RET targets reg_rs=0x0200 with ras_underflow=1.
- Nested calls with pc_plus_two 0x0102 then 0x0204, then two RETs -> targets 0x0204 then 0x0102; ra_write_value=0x0102 on the first JAL.
- SHADOW_SLOTS=2: taken J with stall held high for 3 cycles during SHADOW -> squashing lasts 2 unstalled cycles, and instructions are accepted only afterwards.
- Reset asserted the cycle after a taken JR -> all outputs 0, ras_count=0, and a valid BEQ on the next cycle is accepted.
